lowampa_trig_holdoff: RTL and testbench

//  Per-beam trigger conditioner between beamform_trigger_lowampa and the trigger/scaler consumers.

---
 rtl/lowampa_trig_holdoff_pkg.sv | 18 +
 rtl/lowampa_trig_holdoff_if.sv | 33 +++
 rtl/lowampa_trig_holdoff_chan.sv | 91 +++++++++
 rtl/lowampa_trig_holdoff.sv | 100 ++++++++++
 tb/tb_lowampa_trig_holdoff.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lowampa_trig_holdoff_pkg.sv
// Shared types and constants for the low-amplitude beam trigger holdoff block.
// Latency: n/a (types only).
// Backpressure: n/a; the trigger path has no flow control.
package lowampa_trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    HOLDOFF = 2'd2
  } holdoff_state_t;

  // Trigger class indices: the first index of trig_i/trig_o/count_o
  localparam int REAL = 0;
  localparam int SUB  = 1;

  localparam int SUPPRESS_CNT_W = 16;

endpackage

// File: rtl/lowampa_trig_holdoff_if.sv
// Bus bundle between the beamformer trigger source and the holdoff conditioner.
// Latency: n/a (wires only).
// Backpressure: none; all signals are per-cycle levels or pulses.
// Signals: trig_i/beam_mask_i/holdoff_i/cnt_clr_i toward the conditioner;
//          trig_o/count_o/trig_any_o/suppress_cnt_o back from it.
// master = trigger source side, slave = lowampa_trig_holdoff.
interface lowampa_trig_holdoff_if
  import lowampa_trig_pkg::*;
#(
  parameter int NBEAMS    = 54,
  parameter int HOLDOFF_W = 8
) ();

  logic [1:0][NBEAMS-1:0]    trig_i;
  logic [NBEAMS-1:0]         beam_mask_i;
  logic [HOLDOFF_W-1:0]      holdoff_i;
  logic                      cnt_clr_i;
  logic [1:0][NBEAMS-1:0]    trig_o;
  logic [1:0][NBEAMS-1:0]    count_o;
  logic                      trig_any_o;
  logic [SUPPRESS_CNT_W-1:0] suppress_cnt_o;

  modport master (
    output trig_i, beam_mask_i, holdoff_i, cnt_clr_i,
    input  trig_o, count_o, trig_any_o, suppress_cnt_o
  );

  modport slave (
    input  trig_i, beam_mask_i, holdoff_i, cnt_clr_i,
    output trig_o, count_o, trig_any_o, suppress_cnt_o
  );

endinterface

// File: rtl/lowampa_trig_holdoff_chan.sv
// One trigger channel: IDLE -> STRETCH -> HOLDOFF -> IDLE.
// Latency: 1 cycle from accepted trig_i to trig_o/count_o.
// Backpressure: none; triggers arriving outside IDLE are dropped and flagged.
// Ports: clk_i, rst_i (sync, active high), trig_i, mask_i, holdoff_i in;
//        trig_o (stretched), count_o (1-cycle pulse), suppressed_o (comb) out.
module lowampa_holdoff_chan
  import lowampa_trig_pkg::*;
#(
  parameter int STRETCH_LEN = 4,
  parameter int HOLDOFF_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig_i,
  input  logic                 mask_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic                 trig_o,
  output logic                 count_o,
  output logic                 suppressed_o
);

  localparam int SL_W  = $clog2(STRETCH_LEN + 1);
  localparam int CNT_W = (HOLDOFF_W > SL_W) ? HOLDOFF_W : SL_W;

  holdoff_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HOLDOFF_W-1:0] hold_q, hold_d;
  logic                 count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      count_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  // One counter serves both phases: it counts down the stretch, then is
  // reloaded with the holdoff latched at acceptance (so later holdoff_i
  // changes only take effect on the next trigger).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    count_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_i && !mask_i) begin
          state_d = STRETCH;
          cnt_d   = CNT_W'(STRETCH_LEN - 1);
          hold_d  = holdoff_i;
          count_d = 1'b1;
        end
      end
      STRETCH: begin
        if (cnt_q == '0) begin
          if (hold_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = CNT_W'(hold_q) - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // trig_o comes straight from the state register, so it is glitch-free
  // and high exactly for the STRETCH_LEN cycles spent in STRETCH.
  assign trig_o       = (state_q == STRETCH);
  assign count_o      = count_q;
  // Mask only gates acceptance; a busy channel still reports a dropped trigger.
  assign suppressed_o = trig_i && (state_q != IDLE);

endmodule

// File: rtl/lowampa_trig_holdoff.sv
// Per-beam trigger stretch/holdoff for real and subthreshold classes, plus scaler pulses.
// Latency: 1 cycle trig_i -> trig_o/count_o; trig_any_o lags trig_o by 1 more.
// Backpressure: none; triggers during stretch/holdoff are dropped (counted for class 0).
// Ports: clk_i, rst_i (sync, active high), bus (lowampa_trig_holdoff_if.slave).
// Optional: LOWAMPA_HOLDOFF_SUPPRESS_CNT_EN builds the saturating class-0
// suppressed-trigger counter; otherwise suppress_cnt_o is 0 and cnt_clr_i unused.
module lowampa_trig_holdoff
  import lowampa_trig_pkg::*;
#(
  parameter int NBEAMS      = 54,
  parameter int STRETCH_LEN = 4,
  parameter int HOLDOFF_W   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  lowampa_trig_holdoff_if.slave  bus
);

  logic [1:0][NBEAMS-1:0] trig_w;
  logic [1:0][NBEAMS-1:0] count_w;
  logic [1:0][NBEAMS-1:0] sup_w;
  logic                   trig_any_q;

  for (genvar c = 0; c < 2; c++) begin : g_cls
    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
      lowampa_holdoff_chan #(
        .STRETCH_LEN (STRETCH_LEN),
        .HOLDOFF_W   (HOLDOFF_W)
      ) u_chan (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .trig_i       (bus.trig_i[c][b]),
        .mask_i       (bus.beam_mask_i[b]),
        .holdoff_i    (bus.holdoff_i),
        .trig_o       (trig_w[c][b]),
        .count_o      (count_w[c][b]),
        .suppressed_o (sup_w[c][b])
      );
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_any_q <= 1'b0;
    end else begin
      trig_any_q <= |trig_w[REAL];
    end
  end

  assign bus.trig_o     = trig_w;
  assign bus.count_o    = count_w;
  assign bus.trig_any_o = trig_any_q;

`ifdef LOWAMPA_HOLDOFF_SUPPRESS_CNT_EN
  localparam int POP_W = $clog2(NBEAMS + 1);
  localparam int SUM_W = SUPPRESS_CNT_W + 1;

  logic [POP_W-1:0]          pop;
  logic [SUM_W-1:0]          sum;
  logic [SUPPRESS_CNT_W-1:0] sup_cnt_q, sup_cnt_d;
  logic                      unused_sub_sup;

  // Several class-0 beams can be suppressed in the same cycle.
  always_comb begin
    pop = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      pop = pop + POP_W'(sup_w[REAL][b]);
    end
  end

  // One spare bit catches the carry so the counter saturates instead of wrapping.
  always_comb begin
    sum = SUM_W'(sup_cnt_q) + SUM_W'(pop);
    if (bus.cnt_clr_i) begin
      sup_cnt_d = '0;
    end else if (sum[SUPPRESS_CNT_W]) begin
      sup_cnt_d = '1;
    end else begin
      sup_cnt_d = sum[SUPPRESS_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sup_cnt_q <= '0;
    end else begin
      sup_cnt_q <= sup_cnt_d;
    end
  end

  assign bus.suppress_cnt_o = sup_cnt_q;
  assign unused_sub_sup     = ^sup_w[SUB];
`else
  logic unused_sup;

  assign bus.suppress_cnt_o = '0;
  assign unused_sup         = bus.cnt_clr_i ^ (^sup_w);
`endif

endmodule

// File: tb/tb_lowampa_trig_holdoff.sv
// Directed bench for lowampa_trig_holdoff: stretch, holdoff, re-arm, mask, reset, class independence
// and (with LOWAMPA_HOLDOFF_SUPPRESS_CNT_EN) the saturating suppressed-trigger counter.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_lowampa_trig_holdoff;
  import lowampa_trig_pkg::*;

  localparam int NB = 54;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   npulse;

  always #5 clk = ~clk;

  lowampa_trig_holdoff_if #(.NBEAMS(NB), .HOLDOFF_W(8)) bus ();

  lowampa_trig_holdoff #(.NBEAMS(NB), .STRETCH_LEN(4), .HOLDOFF_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    bus.trig_i      = '0;
    bus.beam_mask_i = '0;
    bus.holdoff_i   = 8'd8;
    bus.cnt_clr_i   = 1'b0;

    // Reset state
    tick(3);
    chk("rst_trig",    32'(|bus.trig_o), 32'd0);
    chk("rst_count",   32'(|bus.count_o), 32'd0);
    chk("rst_any",     32'(bus.trig_any_o), 32'd0);
    chk("rst_supcnt",  32'(bus.suppress_cnt_o), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: single pulse on real beam 3, holdoff 8
    bus.trig_i[REAL][3] = 1'b1;
    tick();                                           // T+1
    chk("t1_trig_k1",  32'(bus.trig_o[REAL][3]), 32'd1);
    chk("t1_cnt_k1",   32'(bus.count_o[REAL][3]), 32'd1);
    chk("t1_only3",    32'(bus.trig_o[REAL] == (NB'(1) << 3)), 32'd1);
    chk("t1_any_k1",   32'(bus.trig_any_o), 32'd0);
    bus.trig_i[REAL][3] = 1'b0;
    tick();                                           // T+2
    chk("t1_trig_k2",  32'(bus.trig_o[REAL][3]), 32'd1);
    chk("t1_cnt_k2",   32'(bus.count_o[REAL][3]), 32'd0);
    chk("t1_any_k2",   32'(bus.trig_any_o), 32'd1);
    tick(2);                                          // T+4
    chk("t1_trig_k4",  32'(bus.trig_o[REAL][3]), 32'd1);
    tick();                                           // T+5
    chk("t1_trig_k5",  32'(bus.trig_o[REAL][3]), 32'd0);
    chk("t1_any_k5",   32'(bus.trig_any_o), 32'd1);
    tick();                                           // T+6
    chk("t1_any_k6",   32'(bus.trig_any_o), 32'd0);
    tick(4);                                          // T+10: pulse in holdoff
    bus.trig_i[REAL][3] = 1'b1;
    tick();                                           // T+11
    chk("t1_ign_cnt",  32'(bus.count_o[REAL][3]), 32'd0);
    chk("t1_ign_trig", 32'(bus.trig_o[REAL][3]), 32'd0);
    bus.trig_i[REAL][3] = 1'b0;
    tick(2);                                          // T+13: back in IDLE
    bus.trig_i[REAL][3] = 1'b1;
    tick();                                           // T+14
    chk("t1_rearm_trig", 32'(bus.trig_o[REAL][3]), 32'd1);
    chk("t1_rearm_cnt",  32'(bus.count_o[REAL][3]), 32'd1);
    bus.trig_i[REAL][3] = 1'b0;
    tick(15);

    // 2: subthreshold beam 0 held for 40 cycles, period 13
    npulse = 0;
    bus.trig_i[SUB][0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.count_o[SUB][0] === 1'b1) npulse++;
      if (k == 14) chk("t2_k14", 32'(bus.count_o[SUB][0]), 32'd1);
      if (k == 13) chk("t2_k13", 32'(bus.count_o[SUB][0]), 32'd0);
    end
    chk("t2_k40",    32'(bus.count_o[SUB][0]), 32'd1);
    chk("t2_pulses", 32'(npulse), 32'd4);
    bus.trig_i[SUB][0] = 1'b0;
    tick(15);

    // 3: holdoff 0, real beam 7 held: 4 high, 1 low, count every 5
    bus.holdoff_i = 8'd0;
    bus.trig_i[REAL][7] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("t3_trig_k%0d", k), 32'(bus.trig_o[REAL][7]), (((k - 1) % 5) < 4) ? 32'd1 : 32'd0);
      chk($sformatf("t3_cnt_k%0d", k),  32'(bus.count_o[REAL][7]), (((k - 1) % 5) == 0) ? 32'd1 : 32'd0);
    end
    bus.trig_i[REAL][7] = 1'b0;
    bus.holdoff_i = 8'd8;
    tick(15);

    // 4: masked beam 5 is ignored; mask raised mid-stretch does not cut it
    bus.beam_mask_i[5] = 1'b1;
    bus.trig_i[REAL][5] = 1'b1;
    tick();
    chk("t4_mask_trig", 32'(bus.trig_o[REAL][5]), 32'd0);
    chk("t4_mask_cnt",  32'(bus.count_o[REAL][5]), 32'd0);
    bus.trig_i[REAL][5] = 1'b0;
    tick();
    chk("t4_mask_trig2", 32'(bus.trig_o[REAL][5]), 32'd0);
    bus.beam_mask_i[5] = 1'b0;
    tick();
    bus.trig_i[REAL][5] = 1'b1;
    tick();                                           // T+1
    chk("t4_acc_trig", 32'(bus.trig_o[REAL][5]), 32'd1);
    bus.trig_i[REAL][5] = 1'b0;
    tick();                                           // T+2
    bus.beam_mask_i[5] = 1'b1;
    tick(2);                                          // T+4
    chk("t4_mid_k4", 32'(bus.trig_o[REAL][5]), 32'd1);
    tick();                                           // T+5
    chk("t4_mid_k5", 32'(bus.trig_o[REAL][5]), 32'd0);
    bus.beam_mask_i[5] = 1'b0;
    tick(15);

    // 5: reset mid-stretch, then immediate acceptance after reset
    bus.trig_i[REAL][9] = 1'b1;
    tick();                                           // T+1
    chk("t5_trig_k1", 32'(bus.trig_o[REAL][9]), 32'd1);
    bus.trig_i[REAL][9] = 1'b0;
    tick();                                           // T+2
    rst = 1'b1;
    tick();                                           // T+3
    chk("t5_rst_trig",  32'(bus.trig_o[REAL][9]), 32'd0);
    chk("t5_rst_all",   32'(|bus.trig_o), 32'd0);
    chk("t5_rst_count", 32'(|bus.count_o), 32'd0);
    chk("t5_rst_any",   32'(bus.trig_any_o), 32'd0);
    rst = 1'b0;
    bus.trig_i[REAL][9] = 1'b1;
    tick();
    chk("t5_post_trig", 32'(bus.trig_o[REAL][9]), 32'd1);
    chk("t5_post_cnt",  32'(bus.count_o[REAL][9]), 32'd1);
    bus.trig_i[REAL][9] = 1'b0;
    tick(15);

    // Real and subthreshold on the same beam in the same cycle
    bus.trig_i[REAL][2] = 1'b1;
    bus.trig_i[SUB][2]  = 1'b1;
    tick();
    chk("both_real", 32'(bus.count_o[REAL][2]), 32'd1);
    chk("both_sub",  32'(bus.count_o[SUB][2]), 32'd1);
    bus.trig_i[REAL][2] = 1'b0;
    bus.trig_i[SUB][2]  = 1'b0;
    tick(15);

`ifdef LOWAMPA_HOLDOFF_SUPPRESS_CNT_EN
    // 6: 3 suppressed in stretch + 2 simultaneous in holdoff = 5
    bus.cnt_clr_i = 1'b1;
    tick();
    bus.cnt_clr_i = 1'b0;
    chk("t6_clr0", 32'(bus.suppress_cnt_o), 32'd0);
    bus.trig_i[REAL][11] = 1'b1;
    bus.trig_i[REAL][12] = 1'b1;
    tick();                                           // both accepted
    bus.trig_i[REAL][12] = 1'b0;
    tick(3);                                          // beam 11 high through T+3
    bus.trig_i[REAL][11] = 1'b0;
    tick();                                           // T+5, holdoff
    bus.trig_i[REAL][11] = 1'b1;
    bus.trig_i[REAL][12] = 1'b1;
    tick();
    bus.trig_i[REAL][11] = 1'b0;
    bus.trig_i[REAL][12] = 1'b0;
    chk("t6_cnt5", 32'(bus.suppress_cnt_o), 32'd5);
    tick(10);
    chk("t6_hold5", 32'(bus.suppress_cnt_o), 32'd5);
    // Saturation: all real beams held high
    bus.trig_i[REAL] = '1;
    tick(1400);
    chk("t6_sat", 32'(bus.suppress_cnt_o), 32'hFFFF);
    tick(5);
    chk("t6_sat_hold", 32'(bus.suppress_cnt_o), 32'hFFFF);
    bus.cnt_clr_i = 1'b1;
    tick();
    chk("t6_clr_wins", 32'(bus.suppress_cnt_o), 32'd0);
    bus.cnt_clr_i = 1'b0;
    bus.trig_i[REAL] = '0;
    tick(15);
`else
    // Counter absent: stays zero under heavy suppression
    bus.trig_i[REAL] = '1;
    bus.cnt_clr_i = 1'b0;
    tick(30);
    chk("t6_off", 32'(bus.suppress_cnt_o), 32'd0);
    bus.trig_i[REAL] = '0;
    tick(15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
